alu_control_md: RTL

Parametrised successor to the single-cycle ALU control decoder. Decodes `ALUop`/`funct` into a 4-bit `ALUcontrol` (full 6-bit funct decode, extended op set, illegal-op flag). Adds an iterative multiply/divide engine with HI/LO registers and a pipeline stall output. Sits in the execute stage beside the main ALU; the hazard unit consumes `stall`.

---
 rtl/alu_ctrl_pkg.sv | 61 ++++++
 rtl/muldiv_iter.sv | 149 ++++++++++++++
 rtl/alu_control_md.sv | 84 ++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and multiply/divide engine.
// Divider support is compiled in only when ALU_DIV_EN is defined.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_MFHI = 4'b1101;
  localparam logic [3:0] C_MFLO = 4'b1110;
  localparam logic [3:0] C_NOP  = 4'b1111;

  typedef logic [1:0] md_state_t;
  localparam md_state_t ST_IDLE = 2'd0;
  localparam md_state_t ST_RUN  = 2'd1;
  localparam md_state_t ST_FIX  = 2'd2;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_op_t;

  function automatic logic is_muldiv(input logic [5:0] f);
`ifdef ALU_DIV_EN
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
`else
    return (f == F_MULT) || (f == F_MULTU);
`endif
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Works on operand magnitudes; signs are restored in the FIX state. Divide path needs ALU_DIV_EN.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  md_op_t            op_in,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  md_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  md_op_t              op_q, op_d;
  logic                neg_lo_q, neg_lo_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d;
`ifdef ALU_DIV_EN
  logic                neg_hi_q, neg_hi_d;
  logic                div0_q, div0_d;
`endif

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] step_next;

  assign a_mag = (op_in.is_signed && opa[DATA_W-1]) ? -opa : opa;
  assign b_mag = (op_in.is_signed && opb[DATA_W-1]) ? -opb : opb;

  // prod holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mul_sum = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);

`ifdef ALU_DIV_EN
  logic [DATA_W:0] div_trial;
  assign div_trial = prod_q[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_q};
  always_comb begin
    if (!op_q.is_div)
      step_next = {mul_sum, prod_q[DATA_W-1:1]};
    else if (div_trial[DATA_W])
      step_next = {prod_q[2*DATA_W-2:0], 1'b0};
    else
      step_next = {div_trial[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b1};
  end
`else
  assign step_next = {mul_sum, prod_q[DATA_W-1:1]};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef ALU_DIV_EN
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          op_d     = op_in;
          prod_d   = {{DATA_W{1'b0}}, (op_in.is_div ? a_mag : b_mag)};
          opnd_d   = op_in.is_div ? b_mag : a_mag;
          neg_lo_d = op_in.is_signed & (opa[DATA_W-1] ^ opb[DATA_W-1]);
`ifdef ALU_DIV_EN
          neg_hi_d = op_in.is_signed & opa[DATA_W-1];
          div0_d   = op_in.is_div & (opb == '0);
`endif
        end
      end
      ST_RUN: begin
        prod_d = step_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1))
          state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!op_q.is_div)
          {hi_d, lo_d} = neg_lo_q ? -prod_q : prod_q;
`ifdef ALU_DIV_EN
        else begin
          // remainder of |a|/0 is |a|, so the dividend sign restores hi = opa
          hi_d = neg_hi_q ? -prod_q[2*DATA_W-1:DATA_W] : prod_q[2*DATA_W-1:DATA_W];
          lo_d = div0_q ? '1 : (neg_lo_q ? -prod_q[DATA_W-1:0] : prod_q[DATA_W-1:0]);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef ALU_DIV_EN
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_lo_q <= neg_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef ALU_DIV_EN
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder with iterative mult/div engine and execute-stage stall.
// Define ALU_DIV_EN to decode and execute div/divu; otherwise they are illegal.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [3:0]        ALUcontrol,
  output logic              illegal,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic   rtype, md_req, start;
  md_op_t op_in;

  always_comb begin
    ALUcontrol = C_ADD;
    illegal    = 1'b0;
    case (ALUop)
      ALUOP_ADD: ALUcontrol = C_ADD;
      ALUOP_SUB: ALUcontrol = C_SUB;
      ALUOP_OR:  ALUcontrol = C_OR;
      default: begin
        case (funct)
          F_ADD:   ALUcontrol = C_ADD;
          F_SUB:   ALUcontrol = C_SUB;
          F_AND:   ALUcontrol = C_AND;
          F_OR:    ALUcontrol = C_OR;
          F_XOR:   ALUcontrol = C_XOR;
          F_NOR:   ALUcontrol = C_NOR;
          F_SLT:   ALUcontrol = C_SLT;
          F_SLTU:  ALUcontrol = C_SLTU;
          F_SLL:   ALUcontrol = C_SLL;
          F_SRL:   ALUcontrol = C_SRL;
          F_SRA:   ALUcontrol = C_SRA;
          F_MFHI:  ALUcontrol = C_MFHI;
          F_MFLO:  ALUcontrol = C_MFLO;
          F_MULT, F_MULTU: ALUcontrol = C_NOP;
`ifdef ALU_DIV_EN
          F_DIV, F_DIVU:   ALUcontrol = C_NOP;
`endif
          default: begin
            ALUcontrol = C_ADD;
            illegal    = 1'b1;
          end
        endcase
      end
    endcase
  end

  // HI/LO readers wait for the engine too, so they never observe stale results
  assign rtype  = (ALUop == ALUOP_RTYPE);
  assign md_req = rtype & is_muldiv(funct);
  assign start  = valid_in & md_req & ~busy;
  assign stall  = valid_in & busy & (md_req | (rtype & ((funct == F_MFHI) | (funct == F_MFLO))));

  assign op_in.is_div    = funct[1];
  assign op_in.is_signed = ~funct[0];

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op_in (op_in),
    .opa   (opa),
    .opb   (opb),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule
